mesi_requester: RTL and testbench

Processor-side MESI controller: the initiator counterpart of the `ouvinte` snooper. It accepts CPU read/write requests and looks them up in a small direct-mapped tag/state array. On a miss or an upgrade it arbitrates for the shared bus and issues the bus transaction that remote snoopers react to. It then installs the resulting MESI state. It sits between the CPU core port and the bus arbiter, beside `ouvinte`, which writes snoop-induced state changes back through a dedicated port.

---
 rtl/mesi_pkg.sv | 30 +++
 rtl/mesi_line_array.sv | 41 ++++
 rtl/mesi_requester.sv | 105 ++++++++++
 tb/tb_mesi_requester.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mesi_pkg.sv
// mesi_pkg: line-state, bus command and FSM encodings for the MESI requester.
// MESI_EXCLUSIVE_EN selects full MESI; undefined builds an MSI controller.
package mesi_pkg;
  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_E = 3'b011;
  localparam logic [2:0] ST_M = 3'b100;
  typedef enum logic [2:0] {
    CMD_NONE    = 3'b000,
    CMD_RD_MISS = 3'b001,
    CMD_WR_MISS = 3'b010,
    CMD_INV     = 3'b011,
    CMD_WB      = 3'b100
  } bus_cmd_t;
  localparam logic [2:0] FSM_IDLE   = 3'd0;
  localparam logic [2:0] FSM_LOOKUP = 3'd1;
  localparam logic [2:0] FSM_ARB    = 3'd2;
  localparam logic [2:0] FSM_WB     = 3'd3;
  localparam logic [2:0] FSM_ISSUE  = 3'd4;
  localparam logic [2:0] FSM_WAIT   = 3'd5;
  localparam logic [2:0] FSM_FILL   = 3'd6;
  // Without the exclusive state, anything that would become E is demoted to S.
  function automatic logic [2:0] proto_state(input logic [2:0] s);
`ifdef MESI_EXCLUSIVE_EN
    return s;
`else
    return (s == ST_E) ? ST_S : s;
`endif
  endfunction
endpackage

// File: rtl/mesi_line_array.sv
// mesi_line_array: direct-mapped tag/state storage with a CPU write port and a
// snoop state-write port; the snoop wins a same-line state write conflict.
module mesi_line_array
  import mesi_pkg::*;
#(
  parameter int LINES = 4,
  parameter int AW    = 8,
  localparam int IW   = $clog2(LINES),
  localparam int TW   = AW - IW
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic [IW-1:0] rd_idx,
  output logic [TW-1:0] rd_tag,
  output logic [2:0]    rd_state,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [2:0]    wr_state,
  input  logic          snp_wr,
  input  logic [IW-1:0] snp_idx,
  input  logic [2:0]    snp_state
);
  logic [TW-1:0] tags   [LINES];
  logic [2:0]    states [LINES];
  assign rd_tag   = tags[rd_idx];
  assign rd_state = states[rd_idx];
  always_ff @(posedge CLK)
    if (!CLR) begin
      for (int i = 0; i < LINES; i++) begin
        tags[i]   <= '0;
        states[i] <= ST_I;
      end
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (wr_en && wr_idx == IW'(i)) tags[i] <= wr_tag;
        if (snp_wr && snp_idx == IW'(i)) states[i] <= proto_state(snp_state);
        else if (wr_en && wr_idx == IW'(i)) states[i] <= wr_state;
      end
    end
endmodule

// File: rtl/mesi_requester.sv
// mesi_requester: processor-side MESI controller issuing bus misses, upgrades and
// victim write-backs. Build with MESI_EXCLUSIVE_EN for MESI, otherwise MSI.
module mesi_requester
  import mesi_pkg::*;
#(
  parameter int LINES = 4,
  parameter int AW    = 8,
  localparam int IW   = $clog2(LINES),
  localparam int TW   = AW - IW
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_done,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [2:0]    bus_cmd,
  output logic [AW-1:0] bus_addr,
  input  logic          bus_shared,
  input  logic          bus_done,
  input  logic          snp_wr,
  input  logic [IW-1:0] snp_idx,
  input  logic [2:0]    snp_state,
  output logic [2:0]    line_state
);
  logic [2:0]    fsm;
  bus_cmd_t      pend_cmd, next_cmd;
  logic          wb_sent, shared_q, hit, victim, wr_en;
  logic [TW-1:0] victim_tag, rd_tag, wr_tag, tag;
  logic [IW-1:0] idx;
  logic [2:0]    rd_state, wr_state;
  assign idx        = cpu_addr[IW-1:0];
  assign tag        = cpu_addr[AW-1:IW];
  assign hit        = rd_tag == tag && rd_state != ST_I;
  assign victim     = !hit && rd_state == ST_M;
  assign line_state = rd_state;
  // Re-derived at grant so snoops that land during ARB are honoured.
  assign next_cmd = !cpu_we ? CMD_RD_MISS : hit ? CMD_INV : CMD_WR_MISS;
  assign bus_req  = fsm != FSM_IDLE && fsm != FSM_LOOKUP;
  assign bus_cmd  = fsm == FSM_ISSUE ? pend_cmd : (fsm == FSM_WB && !wb_sent) ? CMD_WB : CMD_NONE;
  assign bus_addr = fsm == FSM_ISSUE ? cpu_addr : (fsm == FSM_WB && !wb_sent) ? {victim_tag, idx} : '0;
  always_comb begin
    wr_en    = 1'b0;
    wr_tag   = tag;
    wr_state = ST_M;
    if (fsm == FSM_LOOKUP && cpu_we && hit && rd_state == ST_E) wr_en = 1'b1;
    else if (fsm == FSM_WB && bus_done) begin
      wr_en    = 1'b1;
      wr_tag   = victim_tag;
      wr_state = ST_I;
    end else if (fsm == FSM_FILL) begin
      wr_en    = 1'b1;
      wr_state = pend_cmd == CMD_RD_MISS ? (shared_q ? ST_S : proto_state(ST_E)) : ST_M;
    end
  end
  always_ff @(posedge CLK)
    if (!CLR) begin
      fsm        <= FSM_IDLE;
      pend_cmd   <= CMD_NONE;
      victim_tag <= '0;
      wb_sent    <= 1'b0;
      shared_q   <= 1'b0;
      cpu_done   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      case (fsm)
        FSM_IDLE:   if (cpu_req && !cpu_done) fsm <= FSM_LOOKUP;
        FSM_LOOKUP:
          if (hit && !(cpu_we && rd_state == ST_S)) begin
            cpu_done <= 1'b1;
            fsm      <= FSM_IDLE;
          end else fsm <= FSM_ARB;
        FSM_ARB:
          if (bus_gnt) begin
            pend_cmd   <= next_cmd;
            victim_tag <= rd_tag;
            wb_sent    <= 1'b0;
            fsm        <= victim ? FSM_WB : FSM_ISSUE;
          end
        FSM_WB: begin
          wb_sent <= 1'b1;
          if (bus_done) fsm <= FSM_ISSUE;
        end
        FSM_ISSUE:  fsm <= FSM_WAIT;
        FSM_WAIT:
          if (bus_done) begin
            shared_q <= bus_shared;
            fsm      <= FSM_FILL;
          end
        FSM_FILL: begin
          cpu_done <= 1'b1;
          fsm      <= FSM_IDLE;
        end
        default:    fsm <= FSM_IDLE;
      endcase
    end
  mesi_line_array #(.LINES(LINES), .AW(AW)) u_array (
    .CLK(CLK), .CLR(CLR),
    .rd_idx(idx), .rd_tag(rd_tag), .rd_state(rd_state),
    .wr_en(wr_en), .wr_idx(idx), .wr_tag(wr_tag), .wr_state(wr_state),
    .snp_wr(snp_wr), .snp_idx(snp_idx), .snp_state(snp_state)
  );
endmodule

// File: tb/tb_mesi_requester.sv
// tb_mesi_requester: directed scenarios for mesi_requester; expectations for the
// clean read-miss fill follow MESI_EXCLUSIVE_EN (E) or its absence (S).
module tb_mesi_requester;
  logic       CLK = 0, CLR = 0, cpu_req = 0, cpu_we = 0, bus_gnt = 0;
  logic       bus_shared = 0, bus_done = 0, snp_wr = 0;
  logic [7:0] cpu_addr = 0;
  logic [1:0] snp_idx = 0;
  logic [2:0] snp_state = 0;
  logic       cpu_done, bus_req;
  logic [2:0] bus_cmd, line_state;
  logic [7:0] bus_addr;
  int compared = 0, mismatched = 0;
`ifdef MESI_EXCLUSIVE_EN
  localparam logic [2:0] RD_CLEAN = 3'b011;
`else
  localparam logic [2:0] RD_CLEAN = 3'b010;
`endif
  always #5 CLK = ~CLK;
  mesi_requester dut (
    .CLK(CLK), .CLR(CLR), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_done(cpu_done), .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd),
    .bus_addr(bus_addr), .bus_shared(bus_shared), .bus_done(bus_done),
    .snp_wr(snp_wr), .snp_idx(snp_idx), .snp_state(snp_state), .line_state(line_state)
  );
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic start(input logic we, input logic [7:0] addr);
    cpu_we = we; cpu_addr = addr; cpu_req = 1; step();
  endtask
  task automatic snoop(input logic [1:0] i, input logic [2:0] s);
    snp_wr = 1; snp_idx = i; snp_state = s; step(); snp_wr = 0;
  endtask
  task automatic test_reset();
    step(); step();
    compared++; if (cpu_done !== 1'b0) begin mismatched++; $display("FAIL rst_done got %b want 0", cpu_done); end
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("FAIL rst_req got %b want 0", bus_req); end
    compared++; if (bus_cmd !== 3'b000) begin mismatched++; $display("FAIL rst_cmd got %b want 000", bus_cmd); end
    compared++; if (bus_addr !== 8'h00) begin mismatched++; $display("FAIL rst_addr got %h want 00", bus_addr); end
    CLR = 1; cpu_addr = 8'h11; step();
    compared++; if (line_state !== 3'b001) begin mismatched++; $display("FAIL rst_line got %b want 001", line_state); end
  endtask
  task automatic test_read_miss();
    start(0, 8'h11);
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("FAIL rm_lookup_req got %b want 0", bus_req); end
    step();
    compared++; if (bus_req !== 1'b1) begin mismatched++; $display("FAIL rm_arb_req got %b want 1", bus_req); end
    compared++; if (bus_cmd !== 3'b000) begin mismatched++; $display("FAIL rm_arb_cmd got %b want 000", bus_cmd); end
    bus_gnt = 1; step(); bus_gnt = 0;
    compared++; if (bus_cmd !== 3'b001) begin mismatched++; $display("FAIL rm_cmd got %b want 001", bus_cmd); end
    compared++; if (bus_addr !== 8'h11) begin mismatched++; $display("FAIL rm_addr got %h want 11", bus_addr); end
    step();
    compared++; if (bus_cmd !== 3'b000) begin mismatched++; $display("FAIL rm_wait_cmd got %b want 000", bus_cmd); end
    bus_done = 1; bus_shared = 0; step(); bus_done = 0;
    compared++; if (cpu_done !== 1'b0) begin mismatched++; $display("FAIL rm_fill_done got %b want 0", cpu_done); end
    compared++; if (bus_req !== 1'b1) begin mismatched++; $display("FAIL rm_fill_req got %b want 1", bus_req); end
    step();
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL rm_done got %b want 1", cpu_done); end
    compared++; if (line_state !== RD_CLEAN) begin mismatched++; $display("FAIL rm_line got %b want %b", line_state, RD_CLEAN); end
    cpu_req = 0; step();
    compared++; if (cpu_done !== 1'b0) begin mismatched++; $display("FAIL rm_done_pulse got %b want 0", cpu_done); end
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("FAIL rm_req_drop got %b want 0", bus_req); end
  endtask
`ifdef MESI_EXCLUSIVE_EN
  task automatic test_write_hit_e();
    start(1, 8'h11); step();
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL whe_done got %b want 1", cpu_done); end
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("FAIL whe_req got %b want 0", bus_req); end
    compared++; if (line_state !== 3'b100) begin mismatched++; $display("FAIL whe_line got %b want 100", line_state); end
    cpu_req = 0; step();
  endtask
`else
  task automatic test_msi_snoop_filter();
    cpu_addr = 8'h11; snoop(2'd1, 3'b011); step();
    compared++; if (line_state !== 3'b010) begin mismatched++; $display("FAIL msi_snp got %b want 010", line_state); end
  endtask
`endif
  task automatic test_upgrade();
    cpu_addr = 8'h11; snoop(2'd1, 3'b010); step();
    compared++; if (line_state !== 3'b010) begin mismatched++; $display("FAIL up_pre got %b want 010", line_state); end
    start(1, 8'h11); step();
    compared++; if (bus_req !== 1'b1) begin mismatched++; $display("FAIL up_req got %b want 1", bus_req); end
    bus_gnt = 1; step(); bus_gnt = 0;
    compared++; if (bus_cmd !== 3'b011) begin mismatched++; $display("FAIL up_cmd got %b want 011", bus_cmd); end
    compared++; if (bus_addr !== 8'h11) begin mismatched++; $display("FAIL up_addr got %h want 11", bus_addr); end
    step(); bus_done = 1; step(); bus_done = 0; step();
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL up_done got %b want 1", cpu_done); end
    compared++; if (line_state !== 3'b100) begin mismatched++; $display("FAIL up_line got %b want 100", line_state); end
    cpu_req = 0; step();
  endtask
  task automatic test_hit_m();
    start(1, 8'h11); step();
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL hm_wr_done got %b want 1", cpu_done); end
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("FAIL hm_wr_req got %b want 0", bus_req); end
    cpu_req = 0; step();
    start(0, 8'h11); step();
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL hm_rd_done got %b want 1", cpu_done); end
    compared++; if (line_state !== 3'b100) begin mismatched++; $display("FAIL hm_line got %b want 100", line_state); end
    cpu_req = 0; step();
  endtask
  task automatic test_writeback();
    start(0, 8'h21); step();
    bus_gnt = 1; step(); bus_gnt = 0;
    compared++; if (bus_cmd !== 3'b100) begin mismatched++; $display("FAIL wb_cmd got %b want 100", bus_cmd); end
    compared++; if (bus_addr !== 8'h11) begin mismatched++; $display("FAIL wb_addr got %h want 11", bus_addr); end
    step();
    compared++; if (bus_cmd !== 3'b000) begin mismatched++; $display("FAIL wb_hold_cmd got %b want 000", bus_cmd); end
    compared++; if (bus_req !== 1'b1) begin mismatched++; $display("FAIL wb_hold_req got %b want 1", bus_req); end
    bus_done = 1; step(); bus_done = 0;
    compared++; if (bus_cmd !== 3'b001) begin mismatched++; $display("FAIL wb_rm_cmd got %b want 001", bus_cmd); end
    compared++; if (bus_addr !== 8'h21) begin mismatched++; $display("FAIL wb_rm_addr got %h want 21", bus_addr); end
    compared++; if (line_state !== 3'b001) begin mismatched++; $display("FAIL wb_victim got %b want 001", line_state); end
    step(); bus_done = 1; bus_shared = 1; step(); bus_done = 0; bus_shared = 0; step();
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL wb_done got %b want 1", cpu_done); end
    compared++; if (line_state !== 3'b010) begin mismatched++; $display("FAIL wb_line got %b want 010", line_state); end
    cpu_req = 0; step();
  endtask
  task automatic test_snoop_in_arb();
    start(1, 8'h21); step();
    snoop(2'd1, 3'b001);
    compared++; if (line_state !== 3'b001) begin mismatched++; $display("FAIL sa_snp got %b want 001", line_state); end
    bus_gnt = 1; step(); bus_gnt = 0;
    compared++; if (bus_cmd !== 3'b010) begin mismatched++; $display("FAIL sa_cmd got %b want 010", bus_cmd); end
    compared++; if (bus_addr !== 8'h21) begin mismatched++; $display("FAIL sa_addr got %h want 21", bus_addr); end
    step(); bus_done = 1; step(); bus_done = 0; step();
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL sa_done got %b want 1", cpu_done); end
    compared++; if (line_state !== 3'b100) begin mismatched++; $display("FAIL sa_line got %b want 100", line_state); end
    cpu_req = 0; step();
  endtask
  task automatic test_fill_conflict();
    start(0, 8'h02); step();
    bus_gnt = 1; step(); bus_gnt = 0;
    compared++; if (bus_cmd !== 3'b001) begin mismatched++; $display("FAIL fc_cmd got %b want 001", bus_cmd); end
    step(); bus_done = 1; bus_shared = 1; step(); bus_done = 0; bus_shared = 0;
    snoop(2'd2, 3'b100);
    compared++; if (cpu_done !== 1'b1) begin mismatched++; $display("FAIL fc_done got %b want 1", cpu_done); end
    compared++; if (line_state !== 3'b100) begin mismatched++; $display("FAIL fc_line got %b want 100", line_state); end
    cpu_req = 0; step();
  endtask
  task automatic test_done_ignored_and_reset();
    bus_done = 1; step(); bus_done = 0;
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("FAIL di_idle_req got %b want 0", bus_req); end
    compared++; if (cpu_done !== 1'b0) begin mismatched++; $display("FAIL di_idle_done got %b want 0", cpu_done); end
    start(0, 8'h03); step();
    bus_done = 1; step(); bus_done = 0;
    compared++; if (bus_req !== 1'b1) begin mismatched++; $display("FAIL di_arb_req got %b want 1", bus_req); end
    compared++; if (bus_cmd !== 3'b000) begin mismatched++; $display("FAIL di_arb_cmd got %b want 000", bus_cmd); end
    bus_gnt = 1; step(); bus_gnt = 0;
    compared++; if (bus_addr !== 8'h03) begin mismatched++; $display("FAIL di_addr got %h want 03", bus_addr); end
    step(); CLR = 0; step();
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("FAIL mr_req got %b want 0", bus_req); end
    compared++; if (bus_cmd !== 3'b000) begin mismatched++; $display("FAIL mr_cmd got %b want 000", bus_cmd); end
    compared++; if (cpu_done !== 1'b0) begin mismatched++; $display("FAIL mr_done got %b want 0", cpu_done); end
    CLR = 1; cpu_req = 0; cpu_addr = 8'h21; step();
    compared++; if (line_state !== 3'b001) begin mismatched++; $display("FAIL mr_line got %b want 001", line_state); end
    compared++; if (cpu_done !== 1'b0) begin mismatched++; $display("FAIL mr_post_done got %b want 0", cpu_done); end
  endtask
  initial begin
    test_reset();
    test_read_miss();
`ifdef MESI_EXCLUSIVE_EN
    test_write_hit_e();
`else
    test_msi_snoop_filter();
`endif
    test_upgrade();
    test_hit_m();
    test_writeback();
    test_snoop_in_arb();
    test_fill_conflict();
    test_done_ignored_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
